// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle arithmetic/logic ops plus a bit-serial shift-left.
// Optional accumulator operand source is enabled by defining ALU_SEQ_ACC_EN.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       opcode,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   count_q;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] a_op;
  logic             accept;
  logic             load_out;
  logic             start_shift;
  logic [WIDTH-1:0] res_out;
  logic             c_out, v_out;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // Both channels transfer on a rising edge where valid && ready; a producer
  // holds its payload stable while valid is high and ready is low.
  assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == SHIFT);
  assign k        = in2[SHW-1:0];

`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc_q;
  assign a_op = use_acc ? acc_q : in1;
`else
  logic unused_use_acc;
  assign unused_use_acc = use_acc;
  assign a_op = in1;
`endif

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      3'b000: begin
        sum     = {1'b0, a_op} + {1'b0, in2};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_op[MSB] == in2[MSB]) && (alu_res[MSB] != a_op[MSB]);
      end
      3'b001: begin
        // Carry here means "no borrow".
        sum     = {1'b0, a_op} + {1'b0, ~in2} + (WIDTH+1)'(1);
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_op[MSB] != in2[MSB]) && (alu_res[MSB] != a_op[MSB]);
      end
      3'b010: alu_res = a_op & in2;
      3'b011: alu_res = a_op | in2;
      3'b100: alu_res = ~a_op;
      3'b101: alu_res = a_op ^ in2;
      3'b110: begin
        alu_res = ~a_op + WIDTH'(1);
        alu_v   = (a_op == MIN_NEG);
      end
      3'b111: begin
        // The accept edge already performs the first shift step.
        if (k == '0) begin
          alu_res = a_op;
        end else begin
          alu_res = {a_op[MSB-1:0], 1'b0};
          alu_c   = a_op[MSB];
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    start_shift = 1'b0;
    res_out     = alu_res;
    c_out       = alu_c;
    v_out       = alu_v;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == 3'b111 && k > SHW'(1)) begin
            state_d     = SHIFT;
            start_shift = 1'b1;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      SHIFT: begin
        res_out = {work_q[MSB-1:0], 1'b0};
        c_out   = work_q[MSB];
        v_out   = 1'b0;
        if (count_q == SHW'(1)) begin
          state_d  = IDLE;
          load_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_shift) begin
        work_q  <= {a_op[MSB-1:0], 1'b0};
        count_q <= k - SHW'(1);
      end else if (state_q == SHIFT) begin
        work_q  <= {work_q[MSB-1:0], 1'b0};
        count_q <= count_q - SHW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      flags     <= 4'b0000;
      out_valid <= 1'b0;
    end else if (load_out) begin
      out       <= res_out;
      flags     <= {res_out[MSB], (res_out == '0), v_out, c_out};
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_ACC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (load_out) begin
      acc_q <= res_out;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): driver pushes expected {out,flags} into a
// queue at each accept; a monitor pops and compares on every output transfer.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1, in2;
  logic [2:0] opcode;
  logic       use_acc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [3:0] flags;
  logic       busy;

  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          waited;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .opcode(opcode), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flags(flags), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present one op, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic ua, input logic [7:0] eo, input logic [3:0] ef,
                      output int n);
    n = 0;
    in1 = a; in2 = b; opcode = op; use_acc = ua; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({eo, ef});
      #1 in_valid = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out=%0h flags=%0b expected no output", out, flags);
      end else begin
        e = exp_q.pop_front();
        check("out_flags", {20'd0, out, flags}, {20'd0, e});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; opcode = '0;
    use_acc = 1'b0; out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out", out, 8'h00);
    check("rst_flags", flags, 4'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // add with signed overflow, single-cycle valid pulse
    send(8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 4'b1010, waited);
    @(negedge clk); check("add_latency", out_valid, 1'b1);
    @(negedge clk); check("add_one_cycle", out_valid, 1'b0);
    @(posedge clk); #1;

    send(8'h05, 8'h05, 3'b001, 1'b0, 8'h00, 4'b0101, waited);
    send(8'h80, 8'h33, 3'b110, 1'b0, 8'h80, 4'b1010, waited);
    send(8'hA1, 8'h03, 3'b111, 1'b0, 8'h08, 4'b0001, waited);
    @(negedge clk);
    check("shl3_busy1", busy, 1'b1);
    check("shl3_in_ready1", in_ready, 1'b0);
    check("shl3_valid1", out_valid, 1'b0);
    @(negedge clk);
    check("shl3_busy2", busy, 1'b1);
    check("shl3_valid2", out_valid, 1'b0);
    @(negedge clk);
    check("shl3_done_valid", out_valid, 1'b1);
    check("shl3_done_busy", busy, 1'b0);
    @(posedge clk); #1;

    // k=0 and k=1 (upper in2 bits ignored) complete on the accept edge
    send(8'hA1, 8'h00, 3'b111, 1'b0, 8'hA1, 4'b1000, waited);
    @(negedge clk); check("shl0_latency", out_valid, 1'b1);
    @(posedge clk); #1;
    send(8'h81, 8'hF9, 3'b111, 1'b0, 8'h02, 4'b0001, waited);
    @(negedge clk);
    check("shl1_latency", out_valid, 1'b1);
    check("shl1_busy", busy, 1'b0);
    @(posedge clk); #1;

    // backpressure, then drain and accept on the same edge
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'b000, 1'b0, 8'h46, 4'b0000, waited);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out", out, 8'h46);
      check("bp_flags", flags, 4'h0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'hF0, 8'hFF, 3'b101, 1'b0, 8'h0F, 4'b0000, waited);
    check("bp_same_edge_accept", waited, 0);
    send(8'h80, 8'h00, 3'b110, 1'b0, 8'h80, 4'b1010, waited);

    // reset in the middle of a k=7 shift
    send(8'hFF, 8'h07, 3'b111, 1'b0, 8'h80, 4'b1001, waited);
    @(negedge clk); check("pre_rst_busy", busy, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", out, 8'h00);
    check("mid_rst_flags", flags, 4'h0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send(8'h01, 8'h02, 3'b000, 1'b0, 8'h03, 4'b0000, waited);
    @(negedge clk); check("post_rst_add_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // accumulator sequence from a clean reset
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`ifdef ALU_SEQ_ACC_EN
    send(8'h00, 8'h10, 3'b000, 1'b1, 8'h10, 4'b0000, waited);
    send(8'h00, 8'h10, 3'b000, 1'b1, 8'h20, 4'b0000, waited);
    send(8'h00, 8'h10, 3'b000, 1'b1, 8'h30, 4'b0000, waited);
`else
    send(8'h00, 8'h10, 3'b000, 1'b1, 8'h10, 4'b0000, waited);
    send(8'h00, 8'h10, 3'b000, 1'b1, 8'h10, 4'b0000, waited);
    send(8'h00, 8'h10, 3'b000, 1'b1, 8'h10, 4'b0000, waited);
`endif
    check("acc_back_to_back", waited, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
